bitblade_column_ctrl: RTL and testbench

Sequencer for one BitBlade column (16 PEs, weight buffers, shift-accumulate tree, accumulator). Latches a job (precision, beat count, signedness), then:
- drives the per-PE shift codes, sign bits and bitwidth;
- issues accumulator clear;
- streams input/weight beats with an input-buffer handshake, inserting zero bubbles on stalls;
- drains the fixed datapath latency and hands the 28-bit result to a downstream consumer.
It sits between the array-level scheduler and the column datapath.

---
 rtl/bitblade_pkg.sv | 26 ++
 rtl/bitblade_column_ctrl_if.sv | 39 +++
 rtl/bitblade_shift_sign_gen.sv | 43 ++++
 rtl/bitblade_column_ctrl.sv | 134 +++++++++++++
 tb/tb_bitblade_column_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bitblade_pkg.sv
// Shared definitions for the BitBlade column controller.
//   - precision encodings carried on cfg_prec / input_bitwidth
//   - controller state encoding
//   - column geometry (PE count, shift-code width) and default pipeline latency
package bitblade_pkg;

    localparam int NUM_PE           = 16;
    localparam int SHIFT_W          = 3;
    localparam int PIPE_LAT_DEFAULT = 6;

    typedef enum logic [1:0] {
        PREC_2B   = 2'b00,
        PREC_4B   = 2'b01,
        PREC_8B   = 2'b10,
        PREC_RSVD = 2'b11
    } prec_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } state_e;

endpackage

// File: rtl/bitblade_column_ctrl_if.sv
// Bundle between the array scheduler / input buffers / result consumer
// (master side) and the column controller (slave side).
//   job request : start, cfg_prec, cfg_x_signed, cfg_y_signed, cfg_len, busy, cfg_err
//   beat stream : in_valid, in_ready, beat_gate, acc_clear
//   column cfg  : input_bitwidth, signal (3b shift code per PE), sign_x, sign_y
//   result      : out_valid, out_ready
interface bitblade_column_ctrl_if #(
    parameter int LEN_W = 10
);
    logic             start;
    logic [1:0]       cfg_prec;
    logic             cfg_x_signed;
    logic             cfg_y_signed;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic             beat_gate;
    logic             acc_clear;
    logic [1:0]       input_bitwidth;
    logic [47:0]      signal;
    logic [3:0]       sign_x;
    logic [3:0]       sign_y;
    logic             out_valid;
    logic             out_ready;
    logic             cfg_err;

    modport master (
        output start, cfg_prec, cfg_x_signed, cfg_y_signed, cfg_len, in_valid, out_ready,
        input  busy, in_ready, beat_gate, acc_clear, input_bitwidth, signal,
               sign_x, sign_y, out_valid, cfg_err
    );

    modport slave (
        input  start, cfg_prec, cfg_x_signed, cfg_y_signed, cfg_len, in_valid, out_ready,
        output busy, in_ready, beat_gate, acc_clear, input_bitwidth, signal,
               sign_x, sign_y, out_valid, cfg_err
    );
endinterface

// File: rtl/bitblade_shift_sign_gen.sv
// Combinational map from job precision/signedness to per-PE shift codes and
// per-slice sign bits.
//   prec     in  : effective precision (reserved is handled like 8b)
//   x_signed in  : input operands signed
//   y_signed in  : weight operands signed
//   signal   out : 3-bit shift code per PE, PE k at [3k+2:3k]
//   sign_x   out : sign enable per input row slice
//   sign_y   out : sign enable per weight column slice
module bitblade_shift_sign_gen
    import bitblade_pkg::*;
(
    input  prec_e                       prec,
    input  logic                        x_signed,
    input  logic                        y_signed,
    output logic [NUM_PE*SHIFT_W-1:0]   signal,
    output logic [3:0]                  sign_x,
    output logic [3:0]                  sign_y
);

    // PE k sits at row i = k>>2 (input slice) and column j = k&3 (weight
    // slice). The code is the product's offset in 2-bit units: slices are
    // grouped per operand as 4 (8b), 2 (4b) or 1 (2b).
    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        localparam int I = k >> 2;
        localparam int J = k & 3;
        assign signal[k*SHIFT_W +: SHIFT_W] =
            (prec == PREC_2B) ? '0 :
            (prec == PREC_4B) ? SHIFT_W'((I % 2) + (J % 2)) :
                                SHIFT_W'(I + J);
    end

    // A slice carries the sign only when it is the MS slice of its operand.
    for (genvar s = 0; s < 4; s++) begin : g_sign
        localparam logic MS4 = (s % 2) == 1;
        localparam logic MS8 = (s == 3);
        logic ms;
        assign ms = (prec == PREC_2B) ? 1'b1 :
                    (prec == PREC_4B) ? MS4  : MS8;
        assign sign_x[s] = x_signed & ms;
        assign sign_y[s] = y_signed & ms;
    end

endmodule

// File: rtl/bitblade_column_ctrl.sv
// Sequencer for one BitBlade column: latches a job, configures the PEs,
// clears the accumulator, streams beats with bubble insertion, drains the
// datapath latency and presents the result to the consumer.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of bitblade_column_ctrl_if
// Parameters: PIPE_LAT (beat-to-total_output latency), LEN_W (beat count
// width, must match the interface instance).
module bitblade_column_ctrl
    import bitblade_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
    parameter int LEN_W    = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    bitblade_column_ctrl_if.slave   bus
);

    localparam int DCNT_W = $clog2(PIPE_LAT + 1);

    state_e             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic [DCNT_W-1:0]  drain_cnt;

    logic               busy_q, in_ready_q, acc_clear_q, out_valid_q, cfg_err_q;
    logic [1:0]         bw_q;
    logic [47:0]        signal_q;
    logic [3:0]         sign_x_q, sign_y_q;

    prec_e              prec_eff;
    logic [47:0]        signal_n;
    logic [3:0]         sign_x_n, sign_y_n;
    logic               accept;

    // Reserved precision runs the 8b datapath configuration.
    assign prec_eff = (prec_e'(bus.cfg_prec) == PREC_RSVD) ? PREC_8B : prec_e'(bus.cfg_prec);

    bitblade_shift_sign_gen u_gen (
        .prec     (prec_eff),
        .x_signed (bus.cfg_x_signed),
        .y_signed (bus.cfg_y_signed),
        .signal   (signal_n),
        .sign_x   (sign_x_n),
        .sign_y   (sign_y_n)
    );

    // in_ready is only ever high in STREAM, so this is the beat handshake.
    assign accept = in_ready_q & bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            bw_q        <= '0;
            signal_q    <= '0;
            sign_x_q    <= '0;
            sign_y_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Config is captured on the accepting edge so it is
                    // already stable during CFG, a cycle ahead of beat 1.
                    if (bus.start) begin
                        state       <= ST_CFG;
                        busy_q      <= 1'b1;
                        acc_clear_q <= 1'b1;
                        len_q       <= bus.cfg_len;
                        beat_cnt    <= '0;
                        drain_cnt   <= '0;
                        bw_q        <= prec_eff;
                        signal_q    <= signal_n;
                        sign_x_q    <= sign_x_n;
                        sign_y_q    <= sign_y_n;
                        cfg_err_q   <= (prec_e'(bus.cfg_prec) == PREC_RSVD);
                    end
                end
                ST_CFG: begin
                    acc_clear_q <= 1'b0;
                    if (len_q == '0) begin
                        state <= ST_DRAIN;
                    end else begin
                        state      <= ST_STREAM;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt + LEN_W'(1) == len_q) begin
                            state      <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DCNT_W'(PIPE_LAT - 1)) begin
                        state       <= ST_RESULT;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCNT_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.in_ready       = in_ready_q;
    assign bus.beat_gate      = accept;
    assign bus.acc_clear      = acc_clear_q;
    assign bus.input_bitwidth = bw_q;
    assign bus.signal         = signal_q;
    assign bus.sign_x         = sign_x_q;
    assign bus.sign_y         = sign_y_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_bitblade_column_ctrl.sv
module tb_bitblade_column_ctrl;
    import bitblade_pkg::*;

    localparam int PL = 6;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitblade_column_ctrl_if #(.LEN_W(LW)) bus ();

    bitblade_column_ctrl #(.PIPE_LAT(PL), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Shift code = offset of the partial product in 2-bit units, where an
    // operand of P bits is split into P/2 slices of 2 bits.
    function automatic logic [47:0] f_sig(input logic [1:0] p);
        logic [47:0] r;
        int spo, i, j;
        r = '0;
        spo = (p == 2'd0) ? 1 : (p == 2'd1) ? 2 : 4;   // slices per operand
        for (int k = 0; k < 16; k++) begin
            i = k / 4;
            j = k % 4;
            r[3*k +: 3] = 3'((i % spo) + (j % spo));
        end
        return r;
    endfunction

    function automatic logic [3:0] f_sgn(input logic [1:0] p, input logic s);
        logic [3:0] r;
        int spo;
        spo = (p == 2'd0) ? 1 : (p == 2'd1) ? 2 : 4;
        for (int i = 0; i < 4; i++) r[i] = s && ((i % spo) == spo - 1);
        return r;
    endfunction

    function automatic logic [1:0] f_eff(input logic [1:0] p);
        return (p == 2'd3) ? 2'd2 : p;
    endfunction

    bit          m_active = 0, m_cfg = 0, m_result = 0, m_err = 0;
    int          m_beats = 0, m_drain = 0;
    logic [47:0] m_sig = '0;
    logic [3:0]  m_sx = '0, m_sy = '0;
    logic [1:0]  m_bw = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 0; m_cfg <= 0; m_result <= 0; m_err <= 0;
            m_beats <= 0; m_drain <= 0;
            m_sig <= '0; m_sx <= '0; m_sy <= '0; m_bw <= '0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active <= 1;
                m_cfg    <= 1;
                m_beats  <= int'(bus.cfg_len);
                m_drain  <= PL;
                m_bw     <= f_eff(bus.cfg_prec);
                m_sig    <= f_sig(f_eff(bus.cfg_prec));
                m_sx     <= f_sgn(f_eff(bus.cfg_prec), bus.cfg_x_signed);
                m_sy     <= f_sgn(f_eff(bus.cfg_prec), bus.cfg_y_signed);
                m_err    <= (bus.cfg_prec == 2'd3);
            end
        end else if (m_cfg) begin
            m_cfg <= 0;
        end else if (m_beats > 0) begin
            if (bus.in_valid) m_beats <= m_beats - 1;
        end else if (m_drain > 0) begin
            m_drain <= m_drain - 1;
            if (m_drain == 1) m_result <= 1;
        end else if (bus.out_ready) begin
            m_active <= 0;
            m_result <= 0;
        end
    end

    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = m_active && !m_cfg && (m_beats > 0);
        chk("busy",      bus.busy,           m_active);
        chk("acc_clear", bus.acc_clear,      m_cfg);
        chk("in_ready",  bus.in_ready,       exp_rdy);
        chk("beat_gate", bus.beat_gate,      exp_rdy && bus.in_valid);
        chk("out_valid", bus.out_valid,      m_result);
        chk("cfg_err",   bus.cfg_err,        m_err);
        chk("bitwidth",  bus.input_bitwidth, m_bw);
        chk("signal",    bus.signal,         m_sig);
        chk("sign_x",    bus.sign_x,         m_sx);
        chk("sign_y",    bus.sign_y,         m_sy);
    end

    // ---------------- directed stimulus ----------------
    // Cycle 0 of a job is CFG; in_valid for cycle c>=1 comes from vpat[c-1].
    task automatic run_job(input logic [1:0] p, input bit xs, input bit ys, input int len,
                           input logic [15:0] vpat, input int hold, input bit poke,
                           output int n_rdy, output int n_bg, output int n_clr, output int n_ov,
                           output int c_last, output int c_ov, output logic [15:0] bgv,
                           output logic [47:0] sig, output logic [3:0] sx, output logic [3:0] sy,
                           output logic err, output logic [1:0] bw);
        int c, ovc;
        bit done;
        bus.cfg_prec = p; bus.cfg_x_signed = xs; bus.cfg_y_signed = ys;
        bus.cfg_len = LW'(len);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 0; ovc = 0; done = 0; c_last = -1; c_ov = -1; n_bg = 0; n_ov = 0; bgv = '0;
        #2;
        sig = bus.signal; sx = bus.sign_x; sy = bus.sign_y; err = bus.cfg_err; bw = bus.input_bitwidth;
        n_clr = int'(bus.acc_clear);
        n_rdy = int'(bus.in_ready);
        while (!done && c < 200) begin
            @(posedge clk); #1;
            c++;
            bus.start = 1'b0;
            bus.in_valid = (c - 1 < 16) ? vpat[c-1] : 1'b1;
            if (bus.out_valid) begin
                if (c_ov < 0) c_ov = c;
                bus.out_ready = (ovc >= hold);
                if (poke && ovc == 2) bus.start = 1'b1;
                ovc++;
            end else begin
                bus.out_ready = 1'b0;
            end
            #2;
            n_rdy += int'(bus.in_ready);
            n_clr += int'(bus.acc_clear);
            n_ov  += int'(bus.out_valid);
            if (bus.beat_gate) begin n_bg++; c_last = c; end
            if (c - 1 < 16) bgv[c-1] = bus.beat_gate;
            if (bus.out_valid && !bus.out_ready) chk("busy_in_result", bus.busy, 1'b1);
            if (bus.out_valid && bus.out_ready) done = 1;
        end
        chk("job_completes", done, 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0;
        #2;
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_out_valid", bus.out_valid, 1'b0);
    endtask

    int n_rdy, n_bg, n_clr, n_ov, c_last, c_ov;
    logic [15:0] bgv;
    logic [47:0] sig;
    logic [3:0]  sx, sy;
    logic        err;
    logic [1:0]  bw;

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.cfg_prec = 0; bus.cfg_x_signed = 0; bus.cfg_y_signed = 0;
        bus.cfg_len = '0; bus.in_valid = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_signal", bus.signal, 48'h0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 8b signed, 4 beats, no stalls
        run_job(2'b10, 1, 1, 4, 16'hFFFF, 0, 0, n_rdy, n_bg, n_clr, n_ov, c_last, c_ov, bgv, sig, sx, sy, err, bw);
        chk("t1_pe0", sig[2:0], 3'd0);
        chk("t1_pe5", sig[17:15], 3'd2);
        chk("t1_pe15", sig[47:45], 3'd6);
        chk("t1_sign_x", sx, 4'b1000);
        chk("t1_sign_y", sy, 4'b1000);
        chk("t1_bw", bw, 2'b10);
        chk("t1_clr_pulses", n_clr, 1);
        chk("t1_ready_cycles", n_rdy, 4);
        chk("t1_last_beat", c_last, 4);
        chk("t1_ov_delay", c_ov - c_last, PL + 1);

        // 4b unsigned, 3 beats, in_valid 1,0,0,1,1
        run_job(2'b01, 0, 0, 3, 16'h0019, 0, 0, n_rdy, n_bg, n_clr, n_ov, c_last, c_ov, bgv, sig, sx, sy, err, bw);
        chk("t2_gate_pattern", bgv[4:0], 5'b11001);
        chk("t2_beats", n_bg, 3);
        chk("t2_last_beat", c_last, 5);
        chk("t2_ready_cycles", n_rdy, 5);
        chk("t2_sign_x", sx, 4'h0);
        chk("t2_sign_y", sy, 4'h0);
        chk("t2_pe5", sig[17:15], 3'd2);
        chk("t2_pe15", sig[47:45], 3'd2);
        chk("t2_pe10", sig[32:30], 3'd0);

        // 2b, x signed only, zero beats: CFG straight to DRAIN
        run_job(2'b00, 1, 0, 0, 16'hFFFF, 0, 0, n_rdy, n_bg, n_clr, n_ov, c_last, c_ov, bgv, sig, sx, sy, err, bw);
        chk("t3_signal", sig, 48'h0);
        chk("t3_sign_x", sx, 4'hF);
        chk("t3_sign_y", sy, 4'h0);
        chk("t3_ready_cycles", n_rdy, 0);
        chk("t3_ov_cycle", c_ov, PL + 1);

        // consumer stalls 5 cycles in RESULT; a start poked meanwhile is ignored
        run_job(2'b10, 0, 0, 2, 16'hFFFF, 5, 1, n_rdy, n_bg, n_clr, n_ov, c_last, c_ov, bgv, sig, sx, sy, err, bw);
        chk("t4_ov_cycles", n_ov, 6);
        chk("t4_beats", n_bg, 2);

        // reserved precision, 1 beat; new start right after the previous handshake
        run_job(2'b11, 1, 1, 1, 16'hFFFF, 0, 0, n_rdy, n_bg, n_clr, n_ov, c_last, c_ov, bgv, sig, sx, sy, err, bw);
        chk("t5_cfg_err", err, 1'b1);
        chk("t5_pe15", sig[47:45], 3'd6);
        chk("t5_bw", bw, 2'b10);
        chk("t5_sign_x", sx, 4'b1000);
        chk("t5_beats", n_bg, 1);
        run_job(2'b01, 0, 1, 1, 16'hFFFF, 0, 0, n_rdy, n_bg, n_clr, n_ov, c_last, c_ov, bgv, sig, sx, sy, err, bw);
        chk("t5_err_cleared", err, 1'b0);
        chk("t5b_sign_y", sy, 4'b1010);

        // reset during beat 2 of an 8-beat job
        bus.cfg_prec = 2'b10; bus.cfg_x_signed = 1; bus.cfg_y_signed = 1;
        bus.cfg_len = LW'(8); bus.in_valid = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;      // CFG
        @(posedge clk); #1;                        // beat 1
        @(posedge clk); #1;                        // beat 2
        reset = 1'b1;
        @(posedge clk); #3;
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_in_ready", bus.in_ready, 1'b0);
        chk("t6_beat_gate", bus.beat_gate, 1'b0);
        chk("t6_signal", bus.signal, 48'h0);
        chk("t6_sign", {bus.sign_x, bus.sign_y}, 8'h00);
        chk("t6_bw", bus.input_bitwidth, 2'b00);
        chk("t6_acc_clear", bus.acc_clear, 1'b0);
        #1; reset = 1'b0; bus.in_valid = 1'b0;
        n_ov = 0;
        repeat (30) begin
            @(posedge clk); #3;
            n_ov += int'(bus.out_valid);
        end
        chk("t6_no_result", n_ov, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
